// File: rtl/fetch_unit_if.sv
// Halfword instruction bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
    logic        ack_i;
    logic [15:0] dat_i;
    logic [63:0] adr_o;
    logic [1:0]  size_o;

    modport master (
        input  ack_i,
        input  dat_i,
        output adr_o,
        output size_o
    );

    modport slave (
        output ack_i,
        output dat_i,
        input  adr_o,
        input  size_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: assembles each 32-bit instruction from two halfword bus reads and
// redirects to mtvec with the illegal-instruction strobes when decode rejects the word.
module fetch_unit (
    input  logic          clk_i,
    input  logic          reset_i,
    fetch_unit_if.master  bus,
    output logic [31:0]   ir_o,
    input  logic          defined_i,
    input  logic          pause_i,
    input  logic [63:2]   csr_mtvec_i,
    output logic          mpie_mie_o,
    output logic          mie_0_o,
    output logic          mcause_2_o
);

    typedef enum logic [2:0] {
        IDLE,
        L_REQ,
        L_ACK,
        H_REQ,
        H_ACK,
        DECODE
    } state_t;

    localparam logic [63:0] RESET_ADR = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [1:0]  SIZE_IDLE = 2'd0;
    localparam logic [1:0]  SIZE_HALF = 2'd2;

    state_t      state;
    state_t      state_next;
    logic [63:0] adr;
    logic [31:0] ir;
    logic [1:0]  size;
    logic        trap;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DECODE doubles as the request cycle of the next fetch, so it goes straight to L_ACK.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   state_next = L_REQ;
            L_REQ:  state_next = L_ACK;
            L_ACK:  state_next = bus.ack_i ? H_REQ : L_ACK;
            H_REQ:  state_next = H_ACK;
            H_ACK:  state_next = bus.ack_i ? DECODE : H_ACK;
            DECODE: state_next = pause_i ? DECODE : L_ACK;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        size = SIZE_IDLE;
        trap = 1'b0;
        unique case (state)
            L_REQ, L_ACK, H_REQ, H_ACK: size = SIZE_HALF;
            DECODE:                     trap = ~defined_i & ~pause_i;
            default:                    size = SIZE_IDLE;
        endcase
    end

    // The address register always points at the halfword being (or about to be) fetched.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            adr <= RESET_ADR;
            ir  <= 32'd0;
        end else begin
            unique case (state)
                L_ACK: begin
                    if (bus.ack_i) begin
                        ir[15:0] <= bus.dat_i;
                        adr      <= adr + 64'd2;
                    end
                end
                H_ACK: begin
                    if (bus.ack_i) begin
                        ir[31:16] <= bus.dat_i;
                        adr       <= adr + 64'd2;
                    end
                end
                DECODE: begin
                    if (trap) begin
                        adr <= {csr_mtvec_i, 2'b00};
                    end
                end
                default: begin
                    adr <= adr;
                end
            endcase
        end
    end

    assign bus.adr_o  = adr;
    assign bus.size_o = size;
    assign ir_o       = ir;
    assign mpie_mie_o = trap;
    assign mie_0_o    = trap;
    assign mcause_2_o = trap;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written corner sequences,
// and a randomized run against a memory-image model of what each fetched instruction must be.
module tb_fetch_unit;

    localparam logic [63:0] RESET_ADR = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] VEC_ADR   = 64'h7777_7777_7777_7774;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] ir_o;
    logic        defined_i;
    logic        pause_i;
    logic [63:2] csr_mtvec_i;
    logic        mpie_mie_o;
    logic        mie_0_o;
    logic        mcause_2_o;
    logic [2:0]  strobes;

    int testCount = 0;
    int failCount = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .bus         (bus),
        .ir_o        (ir_o),
        .defined_i   (defined_i),
        .pause_i     (pause_i),
        .csr_mtvec_i (csr_mtvec_i),
        .mpie_mie_o  (mpie_mie_o),
        .mie_0_o     (mie_0_o),
        .mcause_2_o  (mcause_2_o)
    );

    assign strobes = {mpie_mie_o, mie_0_o, mcause_2_o};

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rstN;
        logic        ack;
        logic [15:0] dat;
        logic        defd;
        logic        pause;
        logic [63:0] expAdr;
        logic [1:0]  expSize;
        logic [31:0] expIr;
        logic        expStrobe;
    } vector_t;

    vector_t vectors [19];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic applyStimulus(input vector_t v);
        @(negedge clk_i);
        reset_i     = v.rstN;
        bus.ack_i   = v.ack;
        bus.dat_i   = v.dat;
        defined_i   = v.defd;
        pause_i     = v.pause;
        @(posedge clk_i);
        #1;
    endtask

    // Contents of the instruction memory image seen by the random run.
    function automatic logic [15:0] memWord(input logic [63:0] a);
        return a[15:0] ^ {a[23:16], a[31:24]} ^ a[47:32] ^ 16'hC3A5;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] pcExp;
        logic [63:0] pcNext;
        logic [63:0] rnd;
        logic        d;
        logic        strobeSeen;
        logic        aborted;
        int          cycles;
        int          nPause;

        reset_i     = 1'b0;
        bus.ack_i   = 1'b0;
        bus.dat_i   = 16'h0000;
        defined_i   = 1'b1;
        pause_i     = 1'b0;
        csr_mtvec_i = 62'h1DDD_DDDD_DDDD_DDDD;

        // rstN ack dat defd pause | adr size ir strobe
        vectors[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, RESET_ADR,          2'd0, 32'h0000_0000, 1'b0};
        vectors[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, RESET_ADR,          2'd0, 32'h0000_0000, 1'b0};
        vectors[2]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, RESET_ADR,          2'd2, 32'h0000_0000, 1'b0};
        vectors[3]  = '{1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0, RESET_ADR,          2'd2, 32'h0000_0000, 1'b0};
        vectors[4]  = '{1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0, RESET_ADR + 64'd2,  2'd2, 32'h0000_AAAA, 1'b0};
        vectors[5]  = '{1'b1, 1'b1, 16'hBBBB, 1'b1, 1'b0, RESET_ADR + 64'd2,  2'd2, 32'h0000_AAAA, 1'b0};
        vectors[6]  = '{1'b1, 1'b1, 16'hBBBB, 1'b1, 1'b0, RESET_ADR + 64'd4,  2'd0, 32'hBBBB_AAAA, 1'b0};
        vectors[7]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, RESET_ADR + 64'd4,  2'd0, 32'hBBBB_AAAA, 1'b0};
        vectors[8]  = '{1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0, VEC_ADR,            2'd2, 32'hBBBB_AAAA, 1'b0};
        vectors[9]  = '{1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0, VEC_ADR + 64'd2,    2'd2, 32'hBBBB_CCCC, 1'b0};
        vectors[10] = '{1'b1, 1'b1, 16'hDDDD, 1'b0, 1'b0, VEC_ADR + 64'd2,    2'd2, 32'hBBBB_CCCC, 1'b0};
        vectors[11] = '{1'b1, 1'b1, 16'hDDDD, 1'b1, 1'b0, VEC_ADR + 64'd4,    2'd0, 32'hDDDD_CCCC, 1'b0};
        vectors[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, VEC_ADR + 64'd4,    2'd2, 32'hDDDD_CCCC, 1'b0};
        vectors[13] = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, VEC_ADR + 64'd4,    2'd2, 32'hDDDD_CCCC, 1'b0};
        vectors[14] = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, VEC_ADR + 64'd4,    2'd2, 32'hDDDD_CCCC, 1'b0};
        vectors[15] = '{1'b1, 1'b0, 16'h1111, 1'b1, 1'b0, VEC_ADR + 64'd4,    2'd2, 32'hDDDD_CCCC, 1'b0};
        vectors[16] = '{1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, VEC_ADR + 64'd6,    2'd2, 32'hDDDD_1111, 1'b0};
        vectors[17] = '{1'b1, 1'b0, 16'h2222, 1'b1, 1'b0, VEC_ADR + 64'd6,    2'd2, 32'hDDDD_1111, 1'b0};
        vectors[18] = '{1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, VEC_ADR + 64'd8,    2'd0, 32'h2222_1111, 1'b0};

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vectors[i]);
            checkOutput($sformatf("vec%0d adr", i), bus.adr_o, vectors[i].expAdr);
            checkOutput($sformatf("vec%0d size", i), 64'(bus.size_o), 64'(vectors[i].expSize));
            checkOutput($sformatf("vec%0d ir", i), 64'(ir_o), 64'(vectors[i].expIr));
            checkOutput($sformatf("vec%0d strobes", i), 64'(strobes), 64'({3{vectors[i].expStrobe}}));
        end

        // Strobes follow defined_i/pause_i combinationally while in DECODE.
        @(negedge clk_i);
        #1;
        checkOutput("decode legal strobes", 64'(strobes), 64'd0);
        defined_i = 1'b0;
        #1;
        checkOutput("decode illegal strobes", 64'(strobes), 64'h7);
        pause_i = 1'b1;
        #1;
        checkOutput("paused illegal strobes", 64'(strobes), 64'd0);
        @(posedge clk_i);
        #1;
        checkOutput("pause hold adr", bus.adr_o, VEC_ADR + 64'd8);
        checkOutput("pause hold size", 64'(bus.size_o), 64'd0);
        checkOutput("pause hold ir", 64'(ir_o), 64'h2222_1111);
        @(negedge clk_i);
        pause_i = 1'b0;
        #1;
        checkOutput("unpause strobes", 64'(strobes), 64'h7);
        @(posedge clk_i);
        #1;
        checkOutput("unpause trap adr", bus.adr_o, VEC_ADR);
        checkOutput("unpause trap size", 64'(bus.size_o), 64'd2);
        checkOutput("after trap strobes", 64'(strobes), 64'd0);

        // Asynchronous reset in the middle of a fetch takes effect without a clock edge.
        @(negedge clk_i);
        bus.ack_i = 1'b1;
        bus.dat_i = 16'h5555;
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        #1;
        checkOutput("async reset adr", bus.adr_o, RESET_ADR);
        checkOutput("async reset size", 64'(bus.size_o), 64'd0);
        checkOutput("async reset ir", 64'(ir_o), 64'd0);
        checkOutput("async reset strobes", 64'(strobes), 64'd0);
        @(posedge clk_i);
        #1;
        checkOutput("held reset adr", bus.adr_o, RESET_ADR);

        // Randomized run: bus answers from memWord() with random wait states.
        @(negedge clk_i);
        reset_i   = 1'b1;
        defined_i = 1'b1;
        pause_i   = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("rnd cold size", 64'(bus.size_o), 64'd2);
        checkOutput("rnd cold adr", bus.adr_o, RESET_ADR);
        pcExp   = RESET_ADR;
        aborted = 1'b0;

        for (int k = 0; k < 120 && !aborted; k++) begin
            cycles     = 0;
            strobeSeen = 1'b0;
            do begin
                @(negedge clk_i);
                bus.dat_i = memWord(bus.adr_o);
                bus.ack_i = ($urandom_range(0, 3) != 0);
                pause_i   = 1'($urandom_range(0, 1));
                defined_i = 1'($urandom_range(0, 1));
                @(posedge clk_i);
                #1;
                cycles++;
                if (bus.size_o != 2'd0 && strobes != 3'd0) strobeSeen = 1'b1;
            end while (bus.size_o != 2'd0 && cycles < 200);

            if (bus.size_o != 2'd0) begin
                checkOutput("rnd fetch reached decode", 64'(bus.size_o), 64'd0);
                aborted = 1'b1;
            end else begin
                checkOutput("rnd ir", 64'(ir_o), 64'({memWord(pcExp + 64'd2), memWord(pcExp)}));
                checkOutput("rnd next pc", bus.adr_o, pcExp + 64'd4);
                checkOutput("rnd fetch strobes", 64'(strobeSeen), 64'd0);

                rnd = {$urandom(), $urandom()};
                csr_mtvec_i = ($urandom_range(0, 3) == 0) ? 62'h3FFF_FFFF_FFFF_FFFE : rnd[63:2];

                nPause = $urandom_range(0, 2);
                for (int p = 0; p < nPause; p++) begin
                    @(negedge clk_i);
                    pause_i   = 1'b1;
                    defined_i = 1'($urandom_range(0, 1));
                    #1;
                    checkOutput("rnd paused strobes", 64'(strobes), 64'd0);
                    @(posedge clk_i);
                    #1;
                    checkOutput("rnd paused adr", bus.adr_o, pcExp + 64'd4);
                    checkOutput("rnd paused size", 64'(bus.size_o), 64'd0);
                end

                @(negedge clk_i);
                pause_i   = 1'b0;
                d         = 1'($urandom_range(0, 1));
                defined_i = d;
                #1;
                checkOutput("rnd decode strobes", 64'(strobes), 64'({3{~d}}));
                pcNext = d ? pcExp + 64'd4 : {csr_mtvec_i, 2'b00};
                @(posedge clk_i);
                #1;
                checkOutput("rnd redirect adr", bus.adr_o, pcNext);
                checkOutput("rnd redirect size", 64'(bus.size_o), 64'd2);
                pcExp = pcNext;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
